// File: rtl/lenet_conv_top.sv
// rtl/lenet_conv_top.sv - single-channel NxN convolution with ReLU/saturation and global max
module lenet_conv_top #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 11,
    parameter int N             = 5,
    parameter int MAX_WIDTH     = 32,
    parameter int PE_DATA_WIDTH = 22,
    parameter int PE_PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int O    = MAX_WIDTH - N + 1;
    localparam int TAPS = N * N;
    localparam int CW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int TW   = $clog2(TAPS + 1);
    localparam int WAW  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic signed [PE_DATA_WIDTH-1:0] SAT_MAX = PE_DATA_WIDTH'((1 << DATA_WIDTH) - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_ACT, S_DONE} state_t;

    logic [DATA_WIDTH-1:0]    img_mem [0:(2**ADDR_WIDTH)-1];
    logic [PE_PORT_WIDTH-1:0] w_mem   [0:TAPS-1];

    state_t                          state_q, state_d;
    logic signed [PE_DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]           max_q, max_d;
    logic [DATA_WIDTH-1:0]           result_q, result_d;
    logic [CW-1:0]                   ox_q, ox_d, oy_q, oy_d;
    logic [KW-1:0]                   kx_q, kx_d, ky_q, ky_d;
    logic [TW-1:0]                   tap_q, tap_d;

    logic [DATA_WIDTH-1:0]           img_rd_q;
    logic [PE_PORT_WIDTH-1:0]        w_rd_q;
    logic [ADDR_WIDTH-1:0]           img_addr;
    logic [WAW-1:0]                  w_addr;
    logic signed [DATA_WIDTH:0]      pix_s;
    logic signed [PE_PORT_WIDTH-1:0] w_s;
    logic signed [PE_DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]           act;
    logic [KW-1:0]                   kx_nxt, ky_nxt;

`ifdef LENET_TEST_PATTERN_EN
    // Built-in pattern: diagonal ramp image and an identity (centre-tap) kernel
    initial begin
        for (int r = 0; r < MAX_WIDTH; r++)
            for (int c = 0; c < MAX_WIDTH; c++)
                img_mem[r*MAX_WIDTH+c] = DATA_WIDTH'((r + c) % 256);
        for (int i = 0; i < TAPS; i++)
            w_mem[i] = '0;
        w_mem[(N/2)*N + N/2] = PE_PORT_WIDTH'(1);
    end
`endif

    // Tap addresses follow the kx/ky counters; data appears one cycle later
    always_comb begin
        img_addr = (ADDR_WIDTH'(oy_q) + ADDR_WIDTH'(ky_q)) * ADDR_WIDTH'(MAX_WIDTH)
                 + ADDR_WIDTH'(ox_q) + ADDR_WIDTH'(kx_q);
        w_addr   = WAW'(ky_q) * WAW'(N) + WAW'(kx_q);
    end

    // Synchronous-read memories, deliberately outside the reset domain
    always_ff @(posedge clk) begin
        img_rd_q <= img_mem[img_addr];
        w_rd_q   <= w_mem[w_addr];
    end

    // Product of unsigned pixel and signed weight, plus ReLU/saturation of the finished sum
    always_comb begin
        pix_s = {1'b0, img_rd_q};
        w_s   = w_rd_q;
        prod  = PE_DATA_WIDTH'(pix_s) * PE_DATA_WIDTH'(w_s);
        if (acc_q < 0)
            act = '0;
        else if (acc_q > SAT_MAX)
            act = '1;
        else
            act = acc_q[DATA_WIDTH-1:0];
    end

    // Next-state logic: sequencing of taps, outputs and the running maximum
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        max_d    = max_q;
        result_d = result_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        kx_d     = kx_q;
        ky_d     = ky_q;
        tap_d    = tap_q;
        kx_nxt   = (kx_q == KW'(N-1)) ? '0 : kx_q + 1'b1;
        ky_nxt   = (kx_q != KW'(N-1)) ? ky_q : ((ky_q == KW'(N-1)) ? '0 : ky_q + 1'b1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    max_d   = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                end
            end
            S_LOAD: begin
                acc_d   = '0;
                tap_d   = '0;
                kx_d    = kx_nxt;
                ky_d    = ky_nxt;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + prod;
                kx_d  = kx_nxt;
                ky_d  = ky_nxt;
                tap_d = tap_q + 1'b1;
                if (tap_q == TW'(TAPS-1))
                    state_d = S_ACT;
            end
            S_ACT: begin
                if (act > max_q)
                    max_d = act;
                kx_d = '0;
                ky_d = '0;
                if (ox_q == CW'(O-1)) begin
                    ox_d = '0;
                    if (oy_q == CW'(O-1)) begin
                        state_d  = S_DONE;
                        result_d = (act > max_q) ? act : max_q;
                    end else begin
                        oy_d    = oy_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else begin
                    ox_d    = ox_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous abort on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            max_q    <= '0;
            result_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            kx_q     <= '0;
            ky_q     <= '0;
            tap_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            max_q    <= max_d;
            result_q <= result_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            kx_q     <= kx_d;
            ky_q     <= ky_d;
            tap_q    <= tap_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_lenet_conv_top.sv
// tb/tb_lenet_conv_top.sv - randomized self-checking bench for lenet_conv_top against a loop-level model
module tb_lenet_conv_top;
    localparam int MW  = 32;
    localparam int N   = 5;
    localparam int O   = MW - N + 1;
    localparam int RUN = O * O * (N * N + 2) + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;
    int img [MW*MW];
    int w   [N*N];

    lenet_conv_top dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model();
        int m, acc, a;
        m = 0;
        for (int oy = 0; oy < O; oy++)
            for (int ox = 0; ox < O; ox++) begin
                acc = 0;
                for (int ky = 0; ky < N; ky++)
                    for (int kx = 0; kx < N; kx++)
                        acc += img[(oy+ky)*MW + ox + kx] * w[ky*N + kx];
                a = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
                if (a > m) m = a;
            end
        return m;
    endfunction

    task automatic load_mem();
        logic [7:0] b;
        for (int i = 0; i < MW*MW; i++) begin
            b = img[i][7:0];
            dut.img_mem[i] = b;
        end
        for (int i = 0; i < N*N; i++) begin
            b = w[i][7:0];
            dut.w_mem[i] = b;
        end
    endtask

    task automatic run_and_check(input string tag, input int exp, input bit extra_start);
        int busy_cnt, done_cnt, done_at, prev, res_at_done;
        busy_cnt = 0; done_cnt = 0; done_at = -1; res_at_done = -1;
        prev = int'(result);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= RUN + 20; cyc++) begin
            if (cyc == 1) chk({tag, "_result_held_at_start"}, int'(result), prev);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = cyc;
                res_at_done = int'(result);
            end
            start = (extra_start && cyc == 100) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_cnt, RUN);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_latency"}, done_at, RUN);
        chk({tag, "_result_at_done"}, res_at_done, exp);
        chk({tag, "_result_hold"}, int'(result), exp);
    endtask

    initial begin
        int exp;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            #2;
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_result", int'(result), 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_result", int'(result), 0);

        // Ramp image with centre-tap kernel; a second start mid-run must be ignored
        for (int r = 0; r < MW; r++)
            for (int c = 0; c < MW; c++)
                img[r*MW + c] = (r + c) % 256;
        for (int i = 0; i < N*N; i++) w[i] = 0;
        w[(N/2)*N + N/2] = 1;
        load_mem();
        exp = model();
        run_and_check("pattern", exp, 1'b1);
        chk("pattern_result_58", int'(result), 58);

        // Random small pixels with weights in {-1,0,1}
        for (int i = 0; i < MW*MW; i++) img[i] = int'($urandom_range(0, 31));
        for (int i = 0; i < N*N; i++) w[i] = int'($urandom_range(0, 2)) - 1;
        load_mem();
        exp = model();
        run_and_check("random", exp, 1'b0);

        // Asynchronous reset in the middle of a run
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh run after abort: saturation of a large positive sum
        for (int i = 0; i < MW*MW; i++) img[i] = 255;
        for (int i = 0; i < N*N; i++) w[i] = 1;
        load_mem();
        exp = model();
        run_and_check("saturate", exp, 1'b0);
        chk("saturate_result_255", int'(result), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
